// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding, cause field offsets and default source count for irq_ctrl
package irq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    localparam int NSRC_DEF = 4;
    localparam int CAUSE_VALID = 0;
    localparam int CAUSE_ID_LSB = 1;
    localparam int CAUSE_PEND_LSB = 8;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: peripheral/core-facing signals of the interrupt controller
interface irq_ctrl_if #(parameter int NSRC = irq_pkg::NSRC_DEF);
    logic [NSRC-1:0] hwint;
    logic            cfg_we;
    logic [NSRC:0]   cfg_wd;
    logic            irq_ack;
    logic            rfe;
    logic            irq_req;
    logic            in_service;
    logic [31:0]     cause;
    logic [NSRC-1:0] pending;
    logic [NSRC:0]   cfg_rd;
    modport master (output hwint, cfg_we, cfg_wd, irq_ack, rfe,
                    input irq_req, in_service, cause, pending, cfg_rd);
    modport slave  (input hwint, cfg_we, cfg_wd, irq_ack, rfe,
                    output irq_req, in_service, cause, pending, cfg_rd);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) idx = req[i] ? IDW'(i) : idx;
        any = |req;
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-captured, masked, fixed-priority interrupt controller feeding CP0
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int IDW  = $clog2(NSRC)
) (
    input logic       clk,
    input logic       reset,
    irq_ctrl_if.slave bus
);
    state_t          state, state_nxt;
    logic [NSRC-1:0] hwint_q, pending, pend_nxt, clr, elig;
    logic [NSRC:0]   cfg;
    logic [IDW-1:0]  src_id, enc_idx;
    logic            elig_any, ack_take, rfe_take, irq_req, in_service;
    logic [31:0]     cause, cause_nxt;

    assign elig     = cfg[NSRC] ? (pending & cfg[NSRC-1:0]) : '0;
    assign ack_take = (state == REQ) & bus.irq_ack;
    assign rfe_take = (state == SERVICE) & bus.rfe;
    assign clr      = ack_take ? (NSRC'(1) << src_id) : '0;
    // A new edge on the bit being acknowledged survives the clear
    assign pend_nxt = (pending & ~clr) | (bus.hwint & ~hwint_q);

    irq_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_enc (
        .req(elig),
        .idx(enc_idx),
        .any(elig_any)
    );

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && elig_any) ? REQ
                  : ack_take ? SERVICE
                  : rfe_take ? IDLE : state;
        cause_nxt = '0;
        cause_nxt[CAUSE_VALID] = 1'b1;
        cause_nxt[CAUSE_ID_LSB +: IDW] = src_id;
        cause_nxt[CAUSE_PEND_LSB +: NSRC] = pend_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            hwint_q    <= '0;
            pending    <= '0;
            cfg        <= '0;
            src_id     <= '0;
            cause      <= '0;
            irq_req    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            hwint_q    <= bus.hwint;
            pending    <= pend_nxt;
            irq_req    <= state_nxt == REQ;
            in_service <= state_nxt == SERVICE;
            if (bus.cfg_we) cfg <= bus.cfg_wd;
            if (state == IDLE && elig_any) src_id <= enc_idx;
            if (ack_take) cause <= cause_nxt;
            else if (rfe_take) cause <= '0;
        end
    end

    assign bus.irq_req    = irq_req;
    assign bus.in_service = in_service;
    assign bus.cause      = cause;
    assign bus.pending    = pending;
    assign bus.cfg_rd     = cfg;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed-step bench for irq_ctrl with immediate-assertion checks
module tb_irq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    irq_ctrl_if bus ();

    irq_ctrl dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.hwint = '0; bus.cfg_we = 0; bus.cfg_wd = '0; bus.irq_ack = 0; bus.rfe = 0;
        tick(); tick();
        chk("rst_req", 32'(bus.irq_req), 0);
        chk("rst_svc", 32'(bus.in_service), 0);
        chk("rst_cause", bus.cause, 0);
        chk("rst_pend", 32'(bus.pending), 0);
        chk("rst_cfg", 32'(bus.cfg_rd), 0);
        reset = 1'b1;
        tick();
        // single source 2
        bus.cfg_we = 1; bus.cfg_wd = 5'b1_1111;
        tick();
        bus.cfg_we = 0;
        chk("cfg_rd", 32'(bus.cfg_rd), 32'h1F);
        bus.hwint = 4'b0100;
        tick();
        bus.hwint = 4'b0000;
        chk("t1_pend", 32'(bus.pending), 32'h4);
        chk("t1_req_e0", 32'(bus.irq_req), 0);
        tick();
        chk("t1_req_e1", 32'(bus.irq_req), 1);
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
        chk("t1_req_ack", 32'(bus.irq_req), 0);
        chk("t1_svc", 32'(bus.in_service), 1);
        chk("t1_cause", bus.cause, 32'h0000_0005);
        chk("t1_pend_clr", 32'(bus.pending), 0);
        bus.rfe = 1;
        tick();
        bus.rfe = 0;
        chk("t1_svc_rfe", 32'(bus.in_service), 0);
        chk("t1_cause_rfe", bus.cause, 0);
        // sources 3 and 1 together
        bus.hwint = 4'b1010;
        tick();
        bus.hwint = 4'b0000;
        chk("t2_pend", 32'(bus.pending), 32'hA);
        tick();
        chk("t2_req", 32'(bus.irq_req), 1);
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
        chk("t2_cause1", bus.cause, 32'h0000_0803);
        chk("t2_pend1", 32'(bus.pending), 32'h8);
        bus.rfe = 1;
        tick();
        bus.rfe = 0;
        chk("t2_svc_rfe", 32'(bus.in_service), 0);
        chk("t2_req_idle", 32'(bus.irq_req), 0);
        tick();
        chk("t2_req3", 32'(bus.irq_req), 1);
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
        chk("t2_cause3", bus.cause, 32'h0000_0007);
        bus.rfe = 1;
        tick();
        bus.rfe = 0;
        // masked source 0
        bus.cfg_we = 1; bus.cfg_wd = 5'b1_1110;
        tick();
        bus.cfg_we = 0;
        bus.hwint = 4'b0001;
        tick();
        bus.hwint = 4'b0000;
        chk("t3_pend", 32'(bus.pending), 32'h1);
        tick();
        chk("t3_masked_a", 32'(bus.irq_req), 0);
        tick();
        chk("t3_masked_b", 32'(bus.irq_req), 0);
        bus.cfg_we = 1; bus.cfg_wd = 5'b1_1111;
        tick();
        bus.cfg_we = 0;
        chk("t3_unmask_e0", 32'(bus.irq_req), 0);
        tick();
        chk("t3_unmask_e1", 32'(bus.irq_req), 1);
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
        chk("t3_cause", bus.cause, 32'h0000_0001);
        bus.rfe = 1;
        tick();
        bus.rfe = 0;
        // re-edge on the bit being acknowledged
        bus.hwint = 4'b0100;
        tick();
        bus.hwint = 4'b0000;
        tick();
        chk("t4_req", 32'(bus.irq_req), 1);
        bus.hwint = 4'b0100; bus.irq_ack = 1;
        tick();
        bus.hwint = 4'b0000; bus.irq_ack = 0;
        chk("t4_pend_set", 32'(bus.pending), 32'h4);
        chk("t4_cause", bus.cause, 32'h0000_0405);
        chk("t4_svc", 32'(bus.in_service), 1);
        bus.rfe = 1;
        tick();
        bus.rfe = 0;
        tick();
        chk("t4_req_again", 32'(bus.irq_req), 1);
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
        chk("t4_cause_again", bus.cause, 32'h0000_0005);
        bus.rfe = 1;
        tick();
        bus.rfe = 0;
        // stray ack in IDLE, stray rfe in REQ
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
        chk("t5_ack_idle_req", 32'(bus.irq_req), 0);
        chk("t5_ack_idle_svc", 32'(bus.in_service), 0);
        chk("t5_ack_idle_cause", bus.cause, 0);
        bus.hwint = 4'b0001;
        tick();
        bus.hwint = 4'b0000;
        tick();
        chk("t5_req", 32'(bus.irq_req), 1);
        bus.rfe = 1;
        tick();
        bus.rfe = 0;
        chk("t5_rfe_req_req", 32'(bus.irq_req), 1);
        chk("t5_rfe_req_svc", 32'(bus.in_service), 0);
        chk("t5_rfe_req_cause", bus.cause, 0);
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
        chk("t5_cause", bus.cause, 32'h0000_0001);
        // async reset in SERVICE
        bus.hwint = 4'b0011;
        tick();
        bus.hwint = 4'b0010;
        chk("t6_pend", 32'(bus.pending), 32'h3);
        chk("t6_svc", 32'(bus.in_service), 1);
        reset = 1'b0;
        #1;
        chk("t6_req_rst", 32'(bus.irq_req), 0);
        chk("t6_svc_rst", 32'(bus.in_service), 0);
        chk("t6_cause_rst", bus.cause, 0);
        chk("t6_pend_rst", 32'(bus.pending), 0);
        chk("t6_cfg_rst", 32'(bus.cfg_rd), 0);
        #2;
        reset = 1'b1;
        tick();
        chk("t6_pend_rel", 32'(bus.pending), 32'h2);
        tick();
        chk("t6_req_rel", 32'(bus.irq_req), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
